// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, branch/jump resolution and load-use detection.
// Optional feature: define ID_EX_FORWARDING_EN to forward from the M/W stages; otherwise operands come straight from the register file.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] ImmExtD,
    input  logic [31:0] PCD,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic [2:0]  ALUControlD,
    input  logic        ALUSrcD,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        BranchD,
    input  logic        JumpD,
    input  logic [1:0]  ResultSrcD,
    input  logic [31:0] ALUResultM,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic [31:0] ResultW,
    input  logic [4:0]  RdW,
    input  logic        RegWriteW,
    input  logic        ZeroE,
    input  logic        StallE,
    input  logic        FlushE,
    output logic [31:0] SrcAE,
    output logic [31:0] SrcBE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] WriteDataE,
    output logic [31:0] PCTargetE,
    output logic [4:0]  RdE,
    output logic [1:0]  ResultSrcE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        ValidE,
    output logic        PCSrcE,
    output logic        LoadUseStall
);

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  alu_ctrl;
        logic        alu_src;
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic [1:0]  result_src;
        logic        valid;
    } e_reg_t;

    e_reg_t e_d;
    e_reg_t e_q;

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic        hazard_src;
    logic        rs_match;

    assign rs_match = (e_q.rd != 5'd0) && ((e_q.rd == Rs1D) || (e_q.rd == Rs2D));

`ifdef ID_EX_FORWARDING_EN
    // Memory stage is checked first so the youngest producer wins; x0 never matches.
    always_comb begin
        fwd_a = e_q.rd1;
        if (RegWriteM && (RdM != 5'd0) && (RdM == e_q.rs1))
            fwd_a = ALUResultM;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == e_q.rs1))
            fwd_a = ResultW;
    end

    always_comb begin
        fwd_b = e_q.rd2;
        if (RegWriteM && (RdM != 5'd0) && (RdM == e_q.rs2))
            fwd_b = ALUResultM;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == e_q.rs2))
            fwd_b = ResultW;
    end

    assign hazard_src = (e_q.result_src == 2'b01);
`else
    logic unused_fwd_inputs;

    // Without forwarding any in-flight register write must be waited out.
    assign fwd_a             = e_q.rd1;
    assign fwd_b             = e_q.rd2;
    assign hazard_src        = e_q.reg_write;
    assign unused_fwd_inputs = ^{ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW};
`endif

    assign LoadUseStall = e_q.valid && hazard_src && rs_match;

    always_comb begin
        e_d = e_q;
        if (FlushE) begin
            e_d = '0;
        end else if (StallE) begin
            e_d = e_q;
        end else if (LoadUseStall) begin
            e_d = '0;
        end else begin
            e_d.rd1        = RD1D;
            e_d.rd2        = RD2D;
            e_d.imm        = ImmExtD;
            e_d.pc         = PCD;
            e_d.rs1        = Rs1D;
            e_d.rs2        = Rs2D;
            e_d.rd         = RdD;
            e_d.alu_ctrl   = ALUControlD;
            e_d.alu_src    = ALUSrcD;
            e_d.reg_write  = RegWriteD;
            e_d.mem_write  = MemWriteD;
            e_d.branch     = BranchD;
            e_d.jump       = JumpD;
            e_d.result_src = ResultSrcD;
            e_d.valid      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            e_q <= '0;
        else
            e_q <= e_d;
    end

    assign SrcAE       = fwd_a;
    assign SrcBE       = e_q.alu_src ? e_q.imm : fwd_b;
    assign WriteDataE  = fwd_b;
    assign PCTargetE   = e_q.pc + e_q.imm;
    assign ALUControlE = e_q.alu_ctrl;
    assign RdE         = e_q.rd;
    assign ResultSrcE  = e_q.result_src;
    assign RegWriteE   = e_q.reg_write;
    assign MemWriteE   = e_q.mem_write;
    assign ValidE      = e_q.valid;
    assign PCSrcE      = e_q.valid && (e_q.jump || (e_q.branch && ZeroE));

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load, forwarding, load-use bubble/stall, branch/jump, flush and reset priority.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [2:0]  ALUControlD;
    logic        ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD;
    logic [1:0]  ResultSrcD;
    logic [31:0] ALUResultM, ResultW;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic        ZeroE, StallE, FlushE;
    logic [31:0] SrcAE, SrcBE, WriteDataE, PCTargetE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE;
    logic [1:0]  ResultSrcE;
    logic        RegWriteE, MemWriteE, ValidE, PCSrcE, LoadUseStall;

    int checks   = 0;
    int failures = 0;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD),
        .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
        .ZeroE(ZeroE), .StallE(StallE), .FlushE(FlushE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
        .WriteDataE(WriteDataE), .PCTargetE(PCTargetE), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ValidE(ValidE), .PCSrcE(PCSrcE), .LoadUseStall(LoadUseStall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_d();
        RD1D = '0; RD2D = '0; ImmExtD = '0; PCD = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0; ALUControlD = '0;
        ALUSrcD = 0; RegWriteD = 0; MemWriteD = 0; BranchD = 0; JumpD = 0;
        ResultSrcD = '0;
    endtask

    initial begin
        reset = 1; clear_d();
        ALUResultM = '0; RdM = '0; RegWriteM = 0;
        ResultW = '0; RdW = '0; RegWriteW = 0;
        ZeroE = 0; StallE = 0; FlushE = 0;
        tick(); tick();
        reset = 0; settle();

        // Reset state
        check("rst_srca", SrcAE, 32'h0);
        check("rst_srcb", SrcBE, 32'h0);
        check("rst_wdata", WriteDataE, 32'h0);
        check("rst_pctgt", PCTargetE, 32'h0);
        check("rst_valid", {31'b0, ValidE}, 32'h0);
        check("rst_pcsrc", {31'b0, PCSrcE}, 32'h0);
        check("rst_lus", {31'b0, LoadUseStall}, 32'h0);
        check("rst_regwr", {31'b0, RegWriteE}, 32'h0);

        // Plain ADD load, one-cycle latency
        RD1D = 32'd5; RD2D = 32'd7; ALUControlD = 3'b000;
        Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd5; RegWriteD = 1;
        PCD = 32'h100; ImmExtD = 32'h4;
        settle();
        check("pre_load_valid", {31'b0, ValidE}, 32'h0);
        tick();
        check("add_srca", SrcAE, 32'd5);
        check("add_srcb", SrcBE, 32'd7);
        check("add_aluc", {29'b0, ALUControlE}, 32'h0);
        check("add_valid", {31'b0, ValidE}, 32'h1);
        check("add_rd", {27'b0, RdE}, 32'd5);
        check("add_pctgt", PCTargetE, 32'h104);
        check("add_wdata", WriteDataE, 32'd7);
        check("add_lus", {31'b0, LoadUseStall}, 32'h0);

        // Forwarding instruction: rs1=3, rs2=6, immediate operand B
        clear_d();
        Rs1D = 5'd3; RD1D = 32'h55; Rs2D = 5'd6; RD2D = 32'h66;
        RdD = 5'd7; ALUSrcD = 1; ImmExtD = 32'h8; ALUControlD = 3'b101;
        tick();
        RdM = 5'd3; RegWriteM = 1; ALUResultM = 32'h10;
        RdW = 5'd3; RegWriteW = 1; ResultW = 32'h20;
        settle();
        check("fwd_m_wins", SrcAE, FWD ? 32'h10 : 32'h55);
        check("fwd_srcb_imm", SrcBE, 32'h8);
        check("fwd_aluc_slt", {29'b0, ALUControlE}, 32'h5);
        RdM = 5'd0; settle();
        check("fwd_rdm0_w", SrcAE, FWD ? 32'h20 : 32'h55);
        RegWriteW = 0; settle();
        check("fwd_none", SrcAE, 32'h55);
        RdM = 5'd6; settle();
        check("fwd_b_wdata", WriteDataE, FWD ? 32'h10 : 32'h66);
        check("fwd_b_srcb_imm", SrcBE, 32'h8);
        RdM = 5'd0; RegWriteM = 0; RdW = 5'd0; ALUResultM = '0; ResultW = '0;

        // Load into E (rd=4), then dependent consumer in D
        clear_d();
        ResultSrcD = 2'b01; RdD = 5'd4; RegWriteD = 1; Rs1D = 5'd1; Rs2D = 5'd2; RD1D = 32'h11;
        tick();
        clear_d();
        Rs1D = 5'd9; Rs2D = 5'd4; RD1D = 32'h99; RdD = 5'd8; RegWriteD = 1;
        settle();
        check("lus_assert", {31'b0, LoadUseStall}, 32'h1);
        StallE = 1;
        tick();
        check("lus_stall_valid", {31'b0, ValidE}, 32'h1);
        check("lus_stall_rd", {27'b0, RdE}, 32'd4);
        check("lus_stall_rsrc", {30'b0, ResultSrcE}, 32'h1);
        check("lus_stall_srca", SrcAE, 32'h11);
        StallE = 0;
        tick();
        check("bubble_valid", {31'b0, ValidE}, 32'h0);
        check("bubble_regwr", {31'b0, RegWriteE}, 32'h0);
        check("bubble_rd", {27'b0, RdE}, 32'h0);
        check("bubble_lus", {31'b0, LoadUseStall}, 32'h0);
        tick();
        check("consumer_srca", SrcAE, 32'h99);
        check("consumer_rd", {27'b0, RdE}, 32'd8);
        Rs1D = 5'd8; settle();
        check("alu_dep_lus", {31'b0, LoadUseStall}, FWD ? 32'h0 : 32'h1);

        // Branch with wrap-around target
        clear_d();
        BranchD = 1; PCD = 32'hFFFF_FFF0; ImmExtD = 32'h20;
        tick();
        ZeroE = 1; settle();
        check("br_pcsrc", {31'b0, PCSrcE}, 32'h1);
        check("br_target", PCTargetE, 32'h0000_0010);
        ZeroE = 0; settle();
        check("br_nottaken", {31'b0, PCSrcE}, 32'h0);
        ZeroE = 1; FlushE = 1;
        tick();
        FlushE = 0;
        check("flush_valid", {31'b0, ValidE}, 32'h0);
        check("flush_pcsrc", {31'b0, PCSrcE}, 32'h0);
        check("flush_pctgt", PCTargetE, 32'h0);
        ZeroE = 0;

        // Jump with nonzero fields, then reset+flush+stall together
        clear_d();
        JumpD = 1; PCD = 32'h200; ImmExtD = 32'hFFFF_FFFC; MemWriteD = 1;
        ALUControlD = 3'b101; RdD = 5'd9;
        tick();
        check("jmp_pcsrc", {31'b0, PCSrcE}, 32'h1);
        check("jmp_target", PCTargetE, 32'h1FC);
        check("jmp_memwr", {31'b0, MemWriteE}, 32'h1);
        reset = 1; FlushE = 1; StallE = 1;
        tick();
        reset = 0; FlushE = 0; StallE = 0;
        settle();
        check("rstpri_valid", {31'b0, ValidE}, 32'h0);
        check("rstpri_rd", {27'b0, RdE}, 32'h0);
        check("rstpri_aluc", {29'b0, ALUControlE}, 32'h0);
        check("rstpri_memwr", {31'b0, MemWriteE}, 32'h0);
        check("rstpri_pctgt", PCTargetE, 32'h0);
        check("rstpri_pcsrc", {31'b0, PCSrcE}, 32'h0);
        RdM = 5'd0; RegWriteM = 1; ALUResultM = 32'hDEAD_BEEF; settle();
        check("x0_never_fwd", SrcAE, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
